// File: rtl/riscv_pkg.sv
// riscv_pkg: states, accepted opcodes and register-file din select encodings
// shared by the multicycle control unit.
package riscv_pkg;
    typedef enum logic [2:0] {INIT, FETCH, DECODE, EXEC, MEM, WB, ILLEGAL} estado_t;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [1:0] MUX2_MEM   = 2'd0;
    localparam logic [1:0] MUX2_ULA   = 2'd1;
    localparam logic [1:0] MUX2_PC4   = 2'd2;
    localparam logic [1:0] MUX2_PCIMM = 2'd3;
endpackage

// File: rtl/uc_decod.sv
// uc_decod: maps the latched opcode to datapath mux selects and a legality flag.
module uc_decod
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    output logic       sinal_mux1,
    output logic [1:0] sinal_mux2,
    output logic       sinal_mux4,
    output logic       legal
);
    always_comb begin
        sinal_mux1 = 1'b0;
        sinal_mux2 = MUX2_MEM;
        sinal_mux4 = 1'b0;
        legal      = 1'b1;
        case (op)
            OP_BRANCH, OP_OP: begin
                sinal_mux1 = 1'b1;
                sinal_mux2 = MUX2_ULA;
            end
            OP_LOAD:            sinal_mux2 = MUX2_MEM;
            OP_STORE, OP_OPIMM: sinal_mux2 = MUX2_ULA;
            OP_AUIPC:           sinal_mux2 = MUX2_PCIMM;
            OP_JAL:             sinal_mux2 = MUX2_PC4;
            OP_JALR: begin
                sinal_mux2 = MUX2_PC4;
                sinal_mux4 = 1'b1;
            end
            default:            legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 datapath.
// Define UC_INSTRET_EN to add the 64-bit retired-instruction counter output instret.
module unidade_controle
    import riscv_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    output logic       wePC,
    output logic       weIR,
    output logic       weReg,
    output logic       weMem,
    output logic       weMemIns,
    output logic       sinalMux1,
    output logic [1:0] sinalMux2,
    output logic       sinalMux4,
    output logic       erro
`ifdef UC_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);
    estado_t    estado, estado_n;
    logic [6:0] op_q;
    logic       mux1, mux4, legal, sel_ok;
    logic [1:0] mux2;
    logic       is_load, is_store, is_branch;

    uc_decod u_decod (
        .op         (op_q),
        .sinal_mux1 (mux1),
        .sinal_mux2 (mux2),
        .sinal_mux4 (mux4),
        .legal      (legal)
    );

    assign is_load   = op_q == OP_LOAD;
    assign is_store  = op_q == OP_STORE;
    assign is_branch = op_q == OP_BRANCH;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= INIT;
            op_q   <= '0;
        end else begin
            estado <= estado_n;
            if (estado == FETCH)
                op_q <= opcode;
        end
    end

    always_comb begin
        estado_n = estado;
        case (estado)
            INIT:    estado_n = FETCH;
            FETCH:   estado_n = DECODE;
            DECODE:  estado_n = legal ? EXEC : ILLEGAL;
            EXEC:    estado_n = is_branch ? FETCH : (is_load || is_store) ? MEM : WB;
            MEM:     estado_n = is_load ? WB : FETCH;
            WB:      estado_n = FETCH;
            ILLEGAL: estado_n = ILLEGAL;
            default: estado_n = INIT;
        endcase
    end

    // Mux selects follow op_q only once it has been latched for the current instruction.
    assign sel_ok = estado inside {DECODE, EXEC, MEM, WB};

    always_comb begin
        weIR      = estado == FETCH;
        weReg     = estado == WB;
        weMem     = estado == MEM && is_store;
        wePC      = estado == WB || (estado == EXEC && is_branch) || (estado == MEM && is_store);
        weMemIns  = 1'b0;
        erro      = estado == ILLEGAL;
        sinalMux1 = sel_ok ? mux1 : 1'b0;
        sinalMux2 = sel_ok ? mux2 : MUX2_MEM;
        sinalMux4 = sel_ok ? mux4 : 1'b0;
    end

`ifdef UC_INSTRET_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            instret <= '0;
        else if (wePC)
            instret <= instret + 64'd1;
    end
`endif
endmodule
